// File: rtl/fifo_word_packer.sv
// Drains a registered-read FIFO, packing RATIO consecutive words into one wide
// valid/ready word; a flush request emits any partial word with keep mask and last.
module fifo_word_packer #(
   parameter int WIDTH = 8,
   parameter int RATIO = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_fifo_empty,
   output logic                     o_fifo_rd_en,
   input  logic [WIDTH-1:0]         i_fifo_rd_data,
   input  logic                     i_flush,
   output logic                     o_out_valid,
   input  logic                     i_out_ready,
   output logic [WIDTH*RATIO-1:0]   o_out_data,
   output logic [RATIO-1:0]         o_out_keep,
   output logic                     o_out_last,
   output logic                     o_flush_done,
   output logic                     o_busy
);

   localparam int CW = $clog2(RATIO + 1);

   typedef enum logic [1:0] {
      RUN,
      FLUSH_WAIT,
      FLUSH_EMIT
   } packerState_t;

   packerState_t                     r_state;
   packerState_t                     w_nextState;
   logic [RATIO-1:0][WIDTH-1:0]      r_acc;
   logic [CW-1:0]                    r_accCnt;
   logic                             r_inflight;
   logic                             r_outValid;
   logic [RATIO-1:0][WIDTH-1:0]      r_outData;
   logic [RATIO-1:0]                 r_outKeep;
   logic                             r_outLast;

   logic [CW:0]                      w_pending;
   logic                             w_outFree;
   logic                             w_wordDone;
   logic                             w_loadFull;
   logic                             w_loadFlush;
   logic                             w_rdEn;
   logic [RATIO-1:0][WIDTH-1:0]      w_fullWord;
   logic [RATIO-1:0][WIDTH-1:0]      w_partWord;
   logic [RATIO-1:0]                 w_partKeep;

   // Counting the in-flight pop keeps a full accumulator from ever being overrun.
   always_comb begin
      w_pending   = {1'b0, r_accCnt} + {{CW{1'b0}}, r_inflight};
      w_outFree   = !r_outValid || i_out_ready;
      w_wordDone  = (r_accCnt == CW'(RATIO)) ||
                    (r_inflight && (r_accCnt == CW'(RATIO - 1)));
      w_loadFull  = (r_state == RUN) && w_wordDone && w_outFree;
      w_loadFlush = (r_state == FLUSH_EMIT) && (r_accCnt != '0) && w_outFree;
      w_rdEn      = !i_rst && !i_fifo_empty && (r_state == RUN) &&
                    (w_pending < (CW + 1)'(RATIO)) && !i_flush;
   end

   always_comb begin
      w_fullWord = r_acc;
      w_partWord = '0;
      w_partKeep = '0;
      for (int i = 0; i < RATIO; i++) begin
         if (r_inflight && (r_accCnt == CW'(i))) begin
            w_fullWord[i] = i_fifo_rd_data;
         end
         if (CW'(i) < r_accCnt) begin
            w_partWord[i] = r_acc[i];
            w_partKeep[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= RUN;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         RUN:        if (i_flush) w_nextState = FLUSH_WAIT;
         FLUSH_WAIT: if (!r_inflight) w_nextState = FLUSH_EMIT;
         FLUSH_EMIT: if ((r_accCnt == '0) || w_outFree) w_nextState = RUN;
         default:    w_nextState = RUN;
      endcase
   end

   always_comb begin
      o_fifo_rd_en = w_rdEn;
      o_flush_done = (r_state == FLUSH_EMIT) && ((r_accCnt == '0) || w_outFree);
      o_busy       = (r_state != RUN);
   end

   // A pop in flight at reset is simply dropped along with the accumulator.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_acc      <= '0;
         r_accCnt   <= '0;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_rdEn;
         if (w_loadFull || w_loadFlush) begin
            r_accCnt <= '0;
         end else if (r_inflight) begin
            for (int i = 0; i < RATIO; i++) begin
               if (r_accCnt == CW'(i)) begin
                  r_acc[i] <= i_fifo_rd_data;
               end
            end
            r_accCnt <= r_accCnt + CW'(1);
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_outValid <= 1'b0;
         r_outData  <= '0;
         r_outKeep  <= '0;
         r_outLast  <= 1'b0;
      end else if (w_loadFull || w_loadFlush) begin
         r_outValid <= 1'b1;
         r_outData  <= w_loadFlush ? w_partWord : w_fullWord;
         r_outKeep  <= w_loadFlush ? w_partKeep : {RATIO{1'b1}};
         r_outLast  <= w_loadFlush;
      end else if (i_out_ready) begin
         r_outValid <= 1'b0;
      end
   end

   assign o_out_valid = r_outValid;
   assign o_out_data  = r_outData;
   assign o_out_keep  = r_outKeep;
   assign o_out_last  = r_outLast;

endmodule

// File: doc/fifo_word_packer.md
# fifo_word_packer

Read-side drain stage that sits directly downstream of the team's synchronous `fifo`. It pops `WIDTH`-bit words from the FIFO read port, packs `RATIO` consecutive words into one `WIDTH*RATIO`-bit word, and presents it on a valid/ready output stream. A flush request emits any partially packed word with a keep mask and a last marker.

## Interface
- `WIDTH`, 8: FIFO word width in bits.
- `RATIO`, 4: FIFO words per packed output word. Legal range is 2..16.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset. Asynchronous, active-high; release is synchronous to `clk` at the system level.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd_en`  out  1  FIFO pop request.
- `fifo_rd_data`  in  WIDTH  FIFO read data. Valid the cycle after `fifo_rd_en` is high (registered read, 1-cycle latency).
- `flush`  in  1  single-cycle pulse requesting emission of a partial word.
- `out_valid`  out  1  packed word available.
- `out_ready`  in  1  consumer accepts the word when `out_valid && out_ready` at the clock edge.
- `out_data`  out  WIDTH*RATIO  packed word. The first-popped word is in bits [WIDTH-1:0].
- `out_keep`  out  RATIO  per-slot valid mask. Bit i covers slot i.
- `out_last`  out  1  marks a flush-terminated word.
- `flush_done`  out  1  one-cycle pulse when the flush completes.
- `busy`  out  1  high while in FLUSH_WAIT or FLUSH_EMIT.

## Operation
Registers:
- `acc`: RATIO slots.
- `acc_cnt`: 0..RATIO.
- `inflight`: 1 bit; equals registered `fifo_rd_en`.
- Output register: `out_data`, `out_keep`, `out_last`, `out_valid`.
- `pending = acc_cnt + inflight`.

Read issue (combinational):
- `fifo_rd_en = !fifo_empty && state==RUN && pending < RATIO && !flush`.
- Never high while `fifo_empty=1`.

Landing, when `inflight=1`:
- `fifo_rd_data` is written to slot `acc_cnt`.
- `acc_cnt` increments.

Transfer:
- A word is complete when `acc_cnt==RATIO`, or when the final word lands with `acc_cnt==RATIO-1`.
- `out_free = !out_valid || out_ready`.
- If `out_free`: load the output register with `out_keep=all ones`, `out_last=0`, `out_valid=1`, and set `acc_cnt` to 0 at the same edge.
- Otherwise: hold the word in `acc` with `acc_cnt=RATIO`; no new reads are issued (pending = RATIO).

Output register behaviour:
- Holds its contents stable while `out_valid && !out_ready`.
- Clears `out_valid` after a handshake unless it is reloaded at the same edge.

State machine:
- RUN -> FLUSH_WAIT when `flush=1` in RUN. `fifo_rd_en` is forced low that cycle.
- FLUSH_WAIT -> FLUSH_EMIT once `inflight=0`, so the last in-flight word has landed.
- FLUSH_EMIT handling:
  - If `acc_cnt==0`: pulse `flush_done` and return to RUN. Nothing is emitted.
  - If `acc_cnt>0` and `out_free`: load the output with `acc` slots 0..acc_cnt-1, `out_keep=(1<<acc_cnt)-1`, and `out_last=1`. Set unused `out_data` slots to 0, set `acc_cnt` to 0, pulse `flush_done`, and return to RUN.
  - If `acc_cnt==RATIO`: emit as a full word with `out_last=1`.
- `flush` outside RUN is ignored.

Reset (asynchronous, immediate):
- Outputs: `fifo_rd_en=0`, `out_valid=0`, `out_data=0`, `out_keep=0`, `out_last=0`, `flush_done=0`, `busy=0`.
- Internal: state=RUN, `acc_cnt=0`, `inflight=0`.
- A read in flight at reset is discarded. The FIFO is reset by the same domain.

## Timing
- Pop to landing: 1 cycle.
- Landing of the final word to `out_valid`: next edge, when `out_free`.
- Steady-state throughput with `out_ready=1`: one packed word per RATIO+1 cycles. Reads pause for the cycle in which the final word is in flight.
- Flush with a read in flight: FLUSH_WAIT lasts 1 cycle, and FLUSH_EMIT completes in 1 cycle if `out_free`.
- Flush latency with nothing in flight: FLUSH_WAIT is exited at the next edge.
- Back-pressure: `out_ready=0` indefinitely stalls reads after at most RATIO additional words are buffered in `acc`. No data is lost or reordered.

## Test plan
- WIDTH=8, RATIO=4; FIFO holds 11,22,33,44; `out_ready=1` -> exactly 4 `fifo_rd_en` pulses; `out_data=0x44332211`, `out_keep=4'b1111`, `out_last=0`, one `out_valid` cycle.
- 8 words 01..08, `out_ready=0` until `acc_cnt=4` and `out_valid=1` -> `fifo_rd_en` stays low while stalled. After release: 0x04030201, then 0x08070605, in order.
- 3 words AA,BB,CC, then `flush` -> `out_data=0x00CCBBAA`, `out_keep=4'b0111`, `out_last=1`, `flush_done` pulse one cycle after emit setup, `busy` high only during the flush.
- `flush` with `acc_cnt=0` and FIFO empty -> no `out_valid`; `flush_done` pulses within 2 cycles.
- `flush` in the same cycle the FIFO would be popped, with 1 word in flight -> the in-flight word is captured, the pop is suppressed, and the emitted keep count matches the landed words.
- Assert `rst` mid-word with 2 slots filled and a read in flight -> all outputs 0 immediately. After release, a fresh 4-word sequence packs from slot 0 with no residue.
